ysyx_040729_exe_mdu_ctrl: RTL and testbench
===========================================

Name: ysyx_040729_exe_mdu_ctrl

Overview:
Multi-cycle sequencer for the RV64M multiply/divide operations in the EXE stage. It replaces the single-cycle multiplier and divider path for func7[0]=1 R-type ops. Operands are accepted through a valid/ready handshake and the block iterates a shift-add multiplier or a restoring divider. It applies the RISC-V sign, word-length and corner-case rules, then holds the result until the downstream stage takes it. The pipeline stalls EXE while in_ready is low.

Parameters:
DATA_WIDTH, 64, operand/result width; must be even
TAG_WIDTH, 5, width of the destination-register tag carried with the op

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of the in-flight op
in_valid  input  1  op request
in_ready  output  1  block can accept; high only in IDLE
in_func3  input  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
in_len_dw  input  1  1 = 32-bit word op (*W), result sign-extended from bit 31
in_src1  input  DATA_WIDTH  rs1 operand
in_src2  input  DATA_WIDTH  rs2 operand
in_tag  input  TAG_WIDTH  rd tag, returned unchanged
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  downstream accepts result
out_result  output  DATA_WIDTH  result
out_tag  output  TAG_WIDTH  tag of the op in out_result
busy  output  1  state != IDLE

Behaviour:
- **Clock and reset:** one clock domain (clk); rst is synchronous, active-high.
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, out_tag=0, iteration counter=0.
- **States:**
  - IDLE -> BUSY on in_valid&&!flush. The operands, func3, len_dw and tag are latched at this point.
  - IDLE -> DONE instead of BUSY for the special cases below.
  - BUSY -> DONE after the last iteration.
  - DONE -> IDLE on out_ready.
- **Word ops:** when len_dw=1, src1/src2 are reduced to bits [31:0]. They are sign-extended for signed ops and zero-extended for unsigned ops. ITER = DATA_WIDTH/2. Otherwise ITER = DATA_WIDTH.
- **Operand preparation:**
  - Signed operands are converted to magnitudes at acceptance.
  - mulhsu treats only src1 as signed. mulhu and divu/remu treat both as unsigned.
- **Multiply:** radix-2 shift-add over ITER iterations into a 2*ITER-bit product. The product is negated at completion if the operand signs differ.
  - mul returns the low half.
  - mulh/mulhsu/mulhu return the high half.
  - len_dw with func3 001..011 is executed as mul.
- **Divide:** restoring division, one quotient bit per iteration.
  - Quotient is negated if the signs differ (signed ops).
  - Remainder takes the dividend's sign.
- **Final result:** with len_dw=1 the result is {{32{r[31]}}, r[31:0]}.
- **Latency:** accept in cycle 0, iterate in cycles 1..ITER, out_valid first high in cycle ITER+1. out_result, out_tag and out_valid are stable while out_valid=1 and out_ready=0.
- **Back-to-back:** no new op is accepted in the same cycle as out_ready (in_ready=0 in DONE). The minimum issue interval is ITER+2.
- **Special cases:** these go IDLE -> DONE with out_valid in cycle 1.
  - Divide by zero: div/divu quotient = all ones; rem/remu = src1. Word-sized results are then sign-extended.
  - Signed overflow: dividend = most-negative value and divisor = -1 at the op width. Quotient = dividend; remainder = 0.
- **flush:** has priority over everything except rst. In any state the next state is IDLE, out_valid drops next cycle and the result is discarded. An in_valid in the same cycle is not accepted.
- **rst:** rst mid-operation behaves like flush and also restores all reset values.

Optional Feature:
**Macro:** MDU_EARLY_OUT_EN.

**When defined**, these cases also go IDLE -> DONE with out_valid in cycle 1:
- A multiply with either (width-reduced) operand zero; result 0.
- A div/rem with |dividend| < |divisor| and divisor != 0. Quotient is 0 and remainder is the original dividend at the op width.

**When undefined**, these cases take the full ITER iterations. Results are identical either way; only latency differs.

Test Plan:
- mul src1=0x7, src2=0xFFFF_FFFF_FFFF_FFFD, len_dw=0, out_ready=1 -> out_valid in cycle 65, out_result=0xFFFF_FFFF_FFFF_FFEB, out_tag echoes in_tag.
- mulhu src1=src2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. mulh same operands -> 0x0.
- divw src1=0x8000_0000, src2=0xFFFF_FFFF (overflow) -> cycle 1, 0xFFFF_FFFF_8000_0000. remw same operands -> 0x0.
- div src1=-7, src2=0 -> 0xFFFF_FFFF_FFFF_FFFF. rem src1=-7 (0xFFFF_FFFF_FFFF_FFF9), src2=2 -> 0xFFFF_FFFF_FFFF_FFFF (-1). remuw 0x1_0000_0005 by 3 -> 0x2 in cycle 33.
- Hold out_ready=0 for 5 cycles after divu 100/7 -> out_valid and result 14 stable, in_ready=0. Then out_ready=1 -> IDLE next cycle and a new in_valid is accepted.
- Flush at BUSY iteration 10 with in_valid=1 -> IDLE next cycle, no out_valid, op not accepted. rst at iteration 20 -> all outputs at reset values next cycle. With MDU_EARLY_OUT_EN, mul by 0 -> out_valid in cycle 1.

Source files
------------

// File: rtl/ysyx_040729_exe_mdu_ctrl.sv
// Multi-cycle RV64M multiply/divide sequencer for EXE: shift-add multiplier, restoring divider.
// Define MDU_EARLY_OUT_EN to finish zero-operand multiplies and |dividend|<|divisor| divides in one cycle.
module ysyx_040729_exe_mdu_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_func3,
    input  logic                  in_len_dw,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH);

    // Handshake: a transfer happens on a rising edge with valid && ready. in_ready is high only
    // in IDLE and out_valid only in DONE, so an op is never accepted in the cycle a result leaves.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    state_t state;

    logic [CW-1:0] cnt, cnt_last;
    logic [W-1:0]  acc_hi, acc_lo, operand_b;
    logic          len_q, div_q, rem_q, high_q, neg_q, neg_rem_q;

    logic          is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf, special;
    logic [W-1:0]  a_ext, b_ext, mag_a, mag_b, min_neg, dvd_w, spec_res;

    always_comb begin
        is_div = in_func3[2];
        if (is_div) begin
            sgn_a = ~in_func3[0];
            sgn_b = ~in_func3[0];
        end else if (in_len_dw) begin
            sgn_a = 1'b1;
            sgn_b = 1'b1;
        end else begin
            sgn_a = (in_func3[1:0] != 2'b11);
            sgn_b = ~in_func3[1];
        end
        a_ext    = in_len_dw ? {{HW{sgn_a & in_src1[HW-1]}}, in_src1[HW-1:0]} : in_src1;
        b_ext    = in_len_dw ? {{HW{sgn_b & in_src2[HW-1]}}, in_src2[HW-1:0]} : in_src2;
        neg_a    = sgn_a & a_ext[W-1];
        neg_b    = sgn_b & b_ext[W-1];
        mag_a    = neg_a ? -a_ext : a_ext;
        mag_b    = neg_b ? -b_ext : b_ext;
        min_neg  = in_len_dw ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
        dvd_w    = in_len_dw ? {{HW{in_src1[HW-1]}}, in_src1[HW-1:0]} : in_src1;
        div_zero = is_div & (b_ext == '0);
        div_ovf  = is_div & sgn_a & (a_ext == min_neg) & (b_ext == '1);
        special  = div_zero | div_ovf;
        spec_res = '0;
        if (div_zero) begin
            spec_res = in_func3[1] ? dvd_w : '1;
        end else if (div_ovf) begin
            spec_res = in_func3[1] ? '0 : a_ext;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!is_div && (a_ext == '0 || b_ext == '0)) begin
            special = 1'b1;
        end else if (is_div && (mag_a < mag_b)) begin
            special  = 1'b1;
            spec_res = in_func3[1] ? dvd_w : '0;
        end
`endif
    end

    // One iteration: multiply shifts {carry,acc_hi,acc_lo} right; divide shifts left and
    // restores by only keeping the difference when the partial remainder covers the divisor.
    logic [W:0]     sum, shifted;
    logic [W-1:0]   diff, step_hi, step_lo, quo, rmd, raw, fin;
    logic           ge;
    logic [2*W-1:0] prod, prod_s;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
        shifted = {acc_hi, acc_lo[W-1]};
        diff    = shifted[W-1:0] - operand_b;
        ge      = (shifted >= {1'b0, operand_b});
        if (div_q) begin
            step_hi = ge ? diff : shifted[W-1:0];
            step_lo = {acc_lo[W-2:0], ge};
        end else begin
            step_hi = sum[W:1];
            step_lo = {sum[0], acc_lo[W-1:1]};
        end
        // Word multiplies run HW steps, leaving the product HW bits above its natural position.
        prod   = len_q ? ({step_hi, step_lo} >> HW) : {step_hi, step_lo};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -step_lo : step_lo;
        rmd    = neg_rem_q ? -step_hi : step_hi;
        if (div_q) begin
            raw = rem_q ? rmd : quo;
        end else begin
            raw = high_q ? prod_s[2*W-1:W] : prod_s[W-1:0];
        end
        fin = len_q ? {{HW{raw[HW-1]}}, raw[HW-1:0]} : raw;
    end

    assign cnt_last = len_q ? CW'(HW - 1) : CW'(W - 1);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            operand_b  <= '0;
            len_q      <= 1'b0;
            div_q      <= 1'b0;
            rem_q      <= 1'b0;
            high_q     <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        len_q     <= in_len_dw;
                        div_q     <= is_div;
                        rem_q     <= in_func3[1];
                        high_q    <= ~is_div & ~in_len_dw & (in_func3[1:0] != 2'b00);
                        neg_q     <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
                        acc_hi    <= '0;
                        acc_lo    <= (is_div && in_len_dw) ? (mag_a << HW) : mag_a;
                        operand_b <= mag_b;
                        out_tag   <= in_tag;
                        cnt       <= '0;
                        if (special) begin
                            out_result <= spec_res;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt == cnt_last) begin
                        cnt        <= '0;
                        out_result <= fin;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_040729_exe_mdu_ctrl.sv
// Bench for ysyx_040729_exe_mdu_ctrl: directed and random ops against an arithmetic reference.
// Latency expectations follow MDU_EARLY_OUT_EN when the bench is built with it.
module tb_ysyx_040729_exe_mdu_ctrl;
  localparam int W  = 64;
  localparam int TW = 5;

  logic          clk, rst, flush, in_valid, in_ready, in_len_dw;
  logic          out_valid, out_ready, busy;
  logic [2:0]    in_func3;
  logic [W-1:0]  in_src1, in_src2, out_result;
  logic [TW-1:0] in_tag, out_tag;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  ysyx_040729_exe_mdu_ctrl #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func3(in_func3), .in_len_dw(in_len_dw),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic len,
                                             input logic [63:0] s1, input logic [63:0] s2);
    logic [127:0] pa, pb, prod;
    logic [31:0]  w1, w2, wq, wr, wp;
    logic [63:0]  q, r, res;
    int           si1, si2;
    longint       sl1, sl2;
    logic         sgn;
    sgn = ~f3[0];
    if (!f3[2]) begin
      if (len) begin
        wp  = s1[31:0] * s2[31:0];
        res = sx32(wp);
      end else begin
        pa   = (f3[1:0] == 2'b11) ? {64'd0, s1} : {{64{s1[63]}}, s1};
        pb   = f3[1] ? {64'd0, s2} : {{64{s2[63]}}, s2};
        prod = pa * pb;
        res  = (f3[1:0] == 2'b00) ? prod[63:0] : prod[127:64];
      end
    end else if (len) begin
      w1 = s1[31:0];
      w2 = s2[31:0];
      if (w2 == 32'd0) begin
        wq = 32'hFFFF_FFFF; wr = w1;
      end else if (sgn && w1 == 32'h8000_0000 && w2 == 32'hFFFF_FFFF) begin
        wq = w1; wr = 32'd0;
      end else if (sgn) begin
        si1 = w1; si2 = w2;
        wq = si1 / si2; wr = si1 % si2;
      end else begin
        wq = w1 / w2; wr = w1 % w2;
      end
      res = f3[1] ? sx32(wr) : sx32(wq);
    end else begin
      if (s2 == 64'd0) begin
        q = '1; r = s1;
      end else if (sgn && s1 == 64'h8000_0000_0000_0000 && s2 == '1) begin
        q = s1; r = 64'd0;
      end else if (sgn) begin
        sl1 = s1; sl2 = s2;
        q = sl1 / sl2; r = sl1 % sl2;
      end else begin
        q = s1 / s2; r = s1 % s2;
      end
      res = f3[1] ? r : q;
    end
    return res;
  endfunction

`ifdef MDU_EARLY_OUT_EN
  function automatic logic [64:0] op_mag(input logic [63:0] s, input logic len, input logic sgn);
    logic [64:0] v;
    if (len) v = sgn ? {{33{s[31]}}, s[31:0]} : {33'd0, s[31:0]};
    else     v = sgn ? {s[63], s} : {1'b0, s};
    return v[64] ? -v : v;
  endfunction
`endif

  function automatic int ref_latency(input logic [2:0] f3, input logic len,
                                     input logic [63:0] s1, input logic [63:0] s2);
    if (f3[2]) begin
      if (len ? (s2[31:0] == 32'd0) : (s2 == 64'd0)) return 1;
      if (!f3[0] && (len ? (s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF)
                         : (s1 == 64'h8000_0000_0000_0000 && s2 == '1))) return 1;
    end
`ifdef MDU_EARLY_OUT_EN
    if (!f3[2] && (len ? (s1[31:0] == 32'd0 || s2[31:0] == 32'd0) : (s1 == 64'd0 || s2 == 64'd0)))
      return 1;
    if (f3[2] && op_mag(s1, len, ~f3[0]) < op_mag(s2, len, ~f3[0])) return 1;
`endif
    return len ? 33 : 65;
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = {32'($urandom), 32'h8000_0000};
      4: v = 64'($urandom_range(0, 20));
      5: v = 64'd0 - 64'($urandom_range(1, 20));
      6: v = {32'($urandom), 32'hFFFF_FFFF};
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // driver tasks
  task automatic drive_accept(input logic [2:0] f3, input logic len, input logic [63:0] s1,
                              input logic [63:0] s2, input logic [4:0] tag);
    in_func3 = f3; in_len_dw = len; in_src1 = s1; in_src2 = s2; in_tag = tag;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic len,
                        input logic [63:0] s1, input logic [63:0] s2, input logic [4:0] tag,
                        input logic [63:0] exp_r, input int exp_lat);
    int lat;
    logic [63:0] exp_v;
    exp_q.push_back(exp_r);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready before issue got=%b exp=1", name, in_ready);
    end
    drive_accept(f3, len, s1, s2, tag);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    exp_v = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s out_valid timeout got=%b exp=1", name, out_valid);
    end
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency f3=%0d len=%0b s1=%h s2=%h got=%0d exp=%0d",
               name, f3, len, s1, s2, lat, exp_lat);
    end
    total++;
    if (out_result !== exp_v) begin
      bad++;
      $display("FAIL %s result f3=%0d len=%0b s1=%h s2=%h got=%h exp=%h",
               name, f3, len, s1, s2, out_result, exp_v);
    end
    total++;
    if (out_tag !== tag) begin
      bad++;
      $display("FAIL %s tag got=%0d exp=%0d", name, out_tag, tag);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++; if (out_result !== 64'd0) begin bad++; $display("FAIL reset out_result got=%h exp=0", out_result); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset out_tag got=%0d exp=0", out_tag); end
  endtask

  task automatic test_directed();
    run_op("mul_neg", 3'b000, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd17,
           64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("mulhu_max", 3'b011, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulh_m1", 3'b001, 1'b0, '1, '1, 5'd3, 64'h0, 65);
    run_op("divw_ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd4,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf", 3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 64'h0, 1);
    run_op("div_zero", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 5'd6, '1, 1);
    run_op("rem_neg", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 5'd7,
           64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("remuw", 3'b111, 1'b1, 64'h1_0000_0005, 64'h3, 5'd8, 64'h2, 33);
    run_op("remuw_zero", 3'b111, 1'b1, 64'hABCD_0000_8000_0001, 64'h1_0000_0000, 5'd9,
           64'hFFFF_FFFF_8000_0001, 1);
    run_op("mulhw_as_mulw", 3'b001, 1'b1, 64'h7FFF_FFFF, 64'h2, 5'd10,
           64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11,
           64'h8000_0000_0000_0000, 1);
    run_op("mul_zero", 3'b000, 1'b0, 64'h0, 64'h1234, 5'd12, 64'h0,
           ref_latency(3'b000, 1'b0, 64'h0, 64'h1234));
    run_op("divu_small", 3'b101, 1'b0, 64'd5, 64'd100, 5'd13, 64'h0,
           ref_latency(3'b101, 1'b0, 64'd5, 64'd100));
    run_op("rem_small", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd100, 5'd14,
           64'hFFFF_FFFF_FFFF_FFFB, ref_latency(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd100));
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic        len;
    logic [63:0] s1, s2;
    logic [4:0]  tag;
    for (int i = 0; i < 48; i++) begin
      f3  = 3'($urandom_range(0, 7));
      len = 1'($urandom_range(0, 1));
      s1  = rand_operand();
      s2  = rand_operand();
      tag = 5'($urandom_range(0, 31));
      run_op("random", f3, len, s1, s2, tag, ref_result(f3, len, s1, s2),
             ref_latency(f3, len, s1, s2));
    end
  endtask

  task automatic test_backpressure();
    int lat;
    drive_accept(3'b101, 1'b0, 64'd100, 64'd7, 5'd3);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL hold out_valid timeout got=%b exp=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_result !== 64'd14 || out_tag !== 5'd3 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold cycle %0d got valid=%b result=%h tag=%0d in_ready=%b exp valid=1 result=e tag=3 in_ready=0",
                 i, out_valid, out_result, out_tag, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL release got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0", in_ready, out_valid);
    end
    run_op("after_hold", 3'b011, 1'b0, '1, '1, 5'd20, 64'hFFFF_FFFF_FFFF_FFFE, 65);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int n_out;
    int guard;
    in_func3 = 3'b000; in_len_dw = 1'b0; in_src1 = 64'd3; in_src2 = 64'd5; in_tag = 5'd9;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    n_out = 0;
    for (int c = 0; c < 140; c++) begin
      if (in_ready === 1'b1) acc_cyc.push_back(c);
      if (out_valid === 1'b1) begin
        n_out++;
        total++;
        if (out_result !== 64'd15 || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b done cycle %0d got result=%h in_ready=%b exp result=f in_ready=0",
                   c, out_result, in_ready);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    total++;
    if (acc_cyc.size() != 3 || n_out != 2) begin
      bad++;
      $display("FAIL b2b counts got accepts=%0d results=%0d exp accepts=3 results=2", acc_cyc.size(), n_out);
    end
    for (int k = 1; k < acc_cyc.size(); k++) begin
      total++;
      if (acc_cyc[k] - acc_cyc[k-1] != 66) begin
        bad++;
        $display("FAIL b2b interval %0d got=%0d exp=66", k, acc_cyc[k] - acc_cyc[k-1]);
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    drive_accept(3'b000, 1'b0, 64'd123, 64'd456, 5'd11);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; in_src1 = 64'd5; in_src2 = 64'd6; in_tag = 5'd12;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_busy got busy=%b in_ready=%b out_valid=%b exp 0 1 0", busy, in_ready, out_valid);
    end
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_quiet got active cycles=%0d exp=0", seen); end
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_accept got busy=%b exp=0", busy); end
    run_op("after_flush", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 5'd13,
           ref_result(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2), 65);
  endtask

  task automatic test_rst_mid();
    run_op("pre_rst", 3'b000, 1'b0, 64'd3, 64'd5, 5'd7, 64'd15, 65);
    drive_accept(3'b100, 1'b0, 64'd1000, 64'd3, 5'd21);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got=%b exp=0", busy); end
    total++; if (out_result !== 64'd0) begin bad++; $display("FAIL rst_mid out_result got=%h exp=0", out_result); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL rst_mid out_tag got=%0d exp=0", out_tag); end
    run_op("after_rst", 3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd22, '1, 33);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_func3 = 3'b000; in_len_dw = 1'b0; in_src1 = '0; in_src2 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
